// File: rtl/mem_req_packer.sv
// mem_req_packer: packs CPU load/store requests into channel messages and returns load replies
module mem_req_packer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_mask,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        sendable,
  output logic        send_flag,
  output logic [4:0]  send_length,
  output logic [71:0] send_data,
  input  logic        recv_valid,
  input  logic [4:0]  recv_length,
  input  logic [71:0] recv_data,
  output logic        recv_pop
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, DONE} state_t;
  state_t state, state_nx;
  logic we_q, pop_q, err_q, reply_ok, timeout;
  logic [CW-1:0] cnt;
  // Any held message is popped in every state; pop_q masks the cycle after a pop.
  assign recv_pop = rst_n & recv_valid & ~pop_q;
  assign reply_ok = state == WAIT_RESP && recv_pop && recv_length == 5'd4;
  // Timeout fires on the edge where the counter reaches TIMEOUT_CYCLES-1.
  assign timeout  = state == WAIT_RESP && cnt == CW'(TIMEOUT_CYCLES - 2);
  assign send_flag = state == SEND && sendable;
  assign cpu_busy  = state == SEND || state == WAIT_RESP;
  assign cpu_done  = state == DONE;
  assign cpu_err   = err_q;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = cpu_req ? SEND : IDLE;
      SEND:      state_nx = sendable ? (we_q ? DONE : WAIT_RESP) : SEND;
      WAIT_RESP: state_nx = (reply_ok || timeout) ? DONE : WAIT_RESP;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      pop_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt         <= '0;
      cpu_rdata   <= '0;
      send_length <= '0;
      send_data   <= '0;
    end else begin
      state <= state_nx;
      pop_q <= recv_pop;
      err_q <= timeout & ~reply_ok;
      cnt   <= state == WAIT_RESP ? cnt + 1'b1 : '0;
      if (state == IDLE && cpu_req) begin
        we_q        <= cpu_we;
        send_length <= cpu_we ? 5'd9 : 5'd5;
        send_data   <= cpu_we ? {4'h0, cpu_mask, cpu_addr, cpu_wdata} : {40'h0, cpu_addr};
      end
      if (reply_ok) cpu_rdata <= recv_data[31:0];
      else if (timeout) cpu_rdata <= '1;
    end
  end
endmodule
